// File: rtl/heap_pkg.sv
// Shared definitions for the heap controller and the sort nodes below it.
// Holds the entry flag encodings, the sentinel entry and the entry ordering
// functions.
package heap_pkg;

  // Entry flag encodings, stored in the top two bits of an entry.
  localparam logic [1:0] FLAG_NORMAL = 2'b00;
  localparam logic [1:0] FLAG_MIN    = 2'b01;
  localparam logic [1:0] FLAG_MAX    = 2'b11;

  // Widest key the comparison functions accept. Callers zero-extend keys.
  localparam int KEY_MAX_W = 64;

  // Sentinel entry at the default 32-bit width: min flag with zero payload.
  localparam logic [31:0] INIT_ENTRY32 = {FLAG_MIN, 30'b0};

  // Ordering rank of a flag: min below normal below max.
  // The unused encoding 10 is ranked as normal.
  function automatic logic [1:0] flag_rank(input logic [1:0] f);
    case (f)
      FLAG_MIN: return 2'd0;
      FLAG_MAX: return 2'd2;
      default:  return 2'd1;
    endcase
  endfunction

  // a < b. Two normal entries compare by unsigned key. Two min entries, or
  // two max entries, are never strictly less than each other.
  function automatic logic cmp_lt(input logic [1:0]           fa,
                                  input logic [KEY_MAX_W-1:0] ka,
                                  input logic [1:0]           fb,
                                  input logic [KEY_MAX_W-1:0] kb);
    logic [1:0] ra;
    logic [1:0] rb;
    ra = flag_rank(fa);
    rb = flag_rank(fb);
    if (ra != rb) return (ra < rb);
    if (ra == 2'd1) return (ka < kb);
    return 1'b0;
  endfunction

  // a <= b under the same ordering.
  function automatic logic cmp_lte(input logic [1:0]           fa,
                                   input logic [KEY_MAX_W-1:0] ka,
                                   input logic [1:0]           fb,
                                   input logic [KEY_MAX_W-1:0] kb);
    logic [1:0] ra;
    logic [1:0] rb;
    ra = flag_rank(fa);
    rb = flag_rank(fb);
    if (ra != rb) return (ra < rb);
    if (ra == 2'd1) return (ka <= kb);
    return 1'b1;
  endfunction

endpackage

// File: rtl/heap_ctrl.sv
// Root controller of a pipelined heap. Holds the heap top, initialises the
// node levels below it, and pushes accepted candidates into the level-1 node.
// Optional: define HEAP_CTRL_STATS_EN to add accepted/dropped handshake
// counters (acc_cnt, drop_cnt).
//
// state  | meaning
// UNINIT | after reset, heap contents invalid until start
// INIT   | node levels clearing, (1<<LEVELS)+1 cycles, busy=1
// READY  | accepting candidates, in_ready=1
// GAP    | one-cycle wait for the level-1 node writeback
module heap_ctrl
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int LEVELS     = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = {FLAG_MIN, {(DATA_WIDTH-2){1'b0}}}
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] root_data,
  output logic                  node_init,
  output logic                  node_update,
  output logic [ADDR_WIDTH-1:0] node_addr,
  output logic                  node_branch,
  output logic [DATA_WIDTH-1:0] node_data,
  input  logic                  up_we,
  input  logic [DATA_WIDTH-1:0] up_data
`ifdef HEAP_CTRL_STATS_EN
  ,
  output logic [31:0]           acc_cnt,
  output logic [31:0]           drop_cnt
`endif
);

  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    INIT   = 2'd1,
    READY  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int CNT_W = LEVELS + 1;
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(1) << LEVELS;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  root_q, root_d;
  logic                   node_init_q, node_init_d;
  logic                   node_update_q, node_update_d;
  logic [DATA_WIDTH-1:0]  node_data_q, node_data_d;
  logic                   hs;
  logic                   accept;
`ifdef HEAP_CTRL_STATS_EN
  logic [31:0]            acc_q, acc_d;
  logic [31:0]            drop_q, drop_d;
`endif

  assign busy        = (state_q == INIT);
  assign in_ready    = (state_q == READY);
  assign root_data   = root_q;
  assign node_init   = node_init_q;
  assign node_update = node_update_q;
  assign node_data   = node_data_q;
  // Only the root pushes into the level-1 node, always at its single slot.
  assign node_addr   = '0;
  assign node_branch = 1'b0;

  assign hs     = in_valid & in_ready;
  assign accept = cmp_lt(root_q[DATA_WIDTH-1 -: 2], KEY_MAX_W'(root_q[KEY_WIDTH-1:0]),
                         in_data[DATA_WIDTH-1 -: 2], KEY_MAX_W'(in_data[KEY_WIDTH-1:0]));

  // Next-state, init counter, heap top and level-1 command.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    root_d        = root_q;
    node_init_d   = 1'b0;
    node_update_d = 1'b0;
    node_data_d   = node_data_q;
`ifdef HEAP_CTRL_STATS_EN
    acc_d         = acc_q;
    drop_d        = drop_q;
`endif
    if (start) begin
      // Start overrides everything, including a same-cycle writeback.
      state_d     = INIT;
      cnt_d       = INIT_CNT;
      node_init_d = 1'b1;
`ifdef HEAP_CTRL_STATS_EN
      acc_d       = '0;
      drop_d      = '0;
`endif
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == '0) begin
            state_d = READY;
            root_d  = INIT_DATA;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        READY: begin
          if (hs) begin
            if (accept) begin
              state_d       = GAP;
              node_update_d = 1'b1;
              node_data_d   = in_data;
              root_d        = in_data;
`ifdef HEAP_CTRL_STATS_EN
              acc_d         = acc_q + 32'd1;
`endif
            end else begin
`ifdef HEAP_CTRL_STATS_EN
              drop_d        = drop_q + 32'd1;
`endif
            end
          end
        end
        GAP:     state_d = READY;
        default: state_d = state_q;
      endcase
      // The level-1 writeback is the newest view of the heap top.
      if (up_we && (state_q != INIT)) root_d = up_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= UNINIT;
      cnt_q         <= '0;
      root_q        <= INIT_DATA;
      node_init_q   <= 1'b0;
      node_update_q <= 1'b0;
      node_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      root_q        <= root_d;
      node_init_q   <= node_init_d;
      node_update_q <= node_update_d;
      node_data_q   <= node_data_d;
    end
  end

`ifdef HEAP_CTRL_STATS_EN
  assign acc_cnt  = acc_q;
  assign drop_cnt = drop_q;

  // Handshake statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end
`endif

endmodule

// File: tb/tb_heap_ctrl.sv
// Directed bench for heap_ctrl with a node_update scoreboard.
module tb_heap_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [DW-1:0] SENT = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] root_data;
  logic          node_init;
  logic          node_update;
  logic [AW-1:0] node_addr;
  logic          node_branch;
  logic [DW-1:0] node_data;
  logic          up_we;
  logic [DW-1:0] up_data;
`ifdef HEAP_CTRL_STATS_EN
  logic [31:0]   acc_cnt;
  logic [31:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  heap_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .ADDR_WIDTH(AW), .LEVELS(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .root_data(root_data), .node_init(node_init), .node_update(node_update),
    .node_addr(node_addr), .node_branch(node_branch), .node_data(node_data),
    .up_we(up_we), .up_data(up_data)
`ifdef HEAP_CTRL_STATS_EN
    , .acc_cnt(acc_cnt), .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts INIT cycles from the first INIT cycle until in_ready rises.
  task automatic run_init(input string tag);
    int busy_n = 0;
    int init_n = 0;
    int i;
    for (i = 0; i < 100; i++) begin
      if (in_ready) break;
      busy_n += int'(busy);
      init_n += int'(node_init);
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, "_init_pulses"}, 64'(init_n), 64'd1);
    chk({tag, "_ready_after"}, 64'(i), 64'd33);
    chk({tag, "_root_sentinel"}, 64'(root_data), 64'(SENT));
  endtask

  // Monitor: every node_update must match the oldest expected push.
  always @(negedge clk) begin
    if (rstn && node_update) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update: got node_data %0h expected none", node_data);
      end else begin
        chk("node_data", 64'(node_data), 64'(exp_q.pop_front()));
        chk("node_addr", 64'(node_addr), 64'd0);
        chk("node_branch", 64'(node_branch), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] keys [4];
    int idx;
    logic [3:0] acc_mask;

    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    up_we = 1'b0; up_data = '0;
    repeat (3) tick();

    // Reset values.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_node_init", 64'(node_init), 64'd0);
    chk("rst_node_update", 64'(node_update), 64'd0);
    chk("rst_node_data", 64'(node_data), 64'd0);
    chk("rst_root", 64'(root_data), 64'(SENT));
    rstn = 1'b1;
    repeat (2) tick();
    chk("uninit_idle", 64'({busy, in_ready}), 64'd0);

    // Start and full initialisation.
    start = 1'b1; tick(); start = 1'b0;
    run_init("init1");

    // Accept a normal key 0x10 over the min sentinel.
    in_valid = 1'b1; in_data = 32'h0000_0010;
    exp_q.push_back(32'h0000_0010);
    tick(); in_valid = 1'b0;
    chk("gap_in_ready", 64'(in_ready), 64'd0);
    chk("accept_root", 64'(root_data), 64'h10);
    tick();
    chk("gap_done_ready", 64'(in_ready), 64'd1);

    // Root 0x50, candidate 0x40: dropped.
    up_we = 1'b1; up_data = 32'h0000_0050; tick(); up_we = 1'b0;
    chk("up_we_ready_root", 64'(root_data), 64'h50);
    in_valid = 1'b1; in_data = 32'h0000_0040;
    chk("drop_hs_ready", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    chk("drop_stays_ready", 64'(in_ready), 64'd1);
    chk("drop_root", 64'(root_data), 64'h50);
`ifdef HEAP_CTRL_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
    chk("acc_cnt", 64'(acc_cnt), 64'd1);
`endif

    // Accept 0x60, then writeback 0x20 during GAP.
    in_valid = 1'b1; in_data = 32'h0000_0060;
    exp_q.push_back(32'h0000_0060);
    tick(); in_valid = 1'b0;
    up_we = 1'b1; up_data = 32'h0000_0020;
    tick(); up_we = 1'b0;
    chk("gap_writeback_root", 64'(root_data), 64'h20);
    chk("gap_writeback_ready", 64'(in_ready), 64'd1);

    // Back-to-back valid for 4 cycles with increasing keys.
    keys[0] = 32'h30; keys[1] = 32'h40; keys[2] = 32'h50; keys[3] = 32'h60;
    idx = 0; acc_mask = '0;
    for (int c = 0; c < 4; c++) begin
      logic h;
      in_valid = 1'b1; in_data = keys[idx];
      h = in_ready;
      if (h) begin
        exp_q.push_back(keys[idx]);
        acc_mask[c] = 1'b1;
      end
      tick();
      if (h) idx++;
    end
    in_valid = 1'b0;
    chk("b2b_accept_mask", 64'(acc_mask), 64'b0101);
    chk("b2b_pending_key", 64'(in_data), 64'h50);
    chk("b2b_root", 64'(root_data), 64'h40);
    tick();

    // Start during GAP, with a same-cycle writeback that must lose.
    in_valid = 1'b1; in_data = 32'h0000_0070;
    exp_q.push_back(32'h0000_0070);
    tick(); in_valid = 1'b0;
    start = 1'b1; up_we = 1'b1; up_data = 32'h0000_0099;
    tick(); start = 1'b0; up_we = 1'b0;
    chk("start_beats_up_we", 64'(root_data), 64'h70);
`ifdef HEAP_CTRL_STATS_EN
    chk("start_clears_acc", 64'(acc_cnt), 64'd0);
    chk("start_clears_drop", 64'(drop_cnt), 64'd0);
`endif
    run_init("init2");
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of INIT.
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    chk("mid_init_busy", 64'(busy), 64'd1);
    rstn = 1'b0; #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_node_init", 64'(node_init), 64'd0);
    chk("midrst_node_data", 64'(node_data), 64'd0);
    chk("midrst_root", 64'(root_data), 64'(SENT));
    tick(); rstn = 1'b1;
    repeat (3) tick();
    chk("midrst_uninit", 64'({busy, in_ready}), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    run_init("init3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
